// File: rtl/epoch_sched_if.sv
// rtl/epoch_sched_if.sv - phase-controller handshake between epoch_sched and the controller
interface epoch_sched_if #(
  parameter int ADDR_W = 8
);
  logic              TR;
  logic              VL;
  logic              END;
  logic [ADDR_W-1:0] sample_addr;
  logic              S_Train;
  logic              S_Error;
  logic              val_miss;

  modport master (
    output TR, VL, END, sample_addr,
    input  S_Train, S_Error, val_miss
  );

  modport slave (
    input  TR, VL, END, sample_addr,
    output S_Train, S_Error, val_miss
  );
endinterface

// File: rtl/epoch_sched.sv
// rtl/epoch_sched.sv - epoch sequencer issuing TR/VL passes; EPOCH_SCHED_EARLY_STOP_EN enables early stop on a clean validation pass
module epoch_sched #(
  parameter int N_TRAIN = 16,
  parameter int N_VAL   = 4,
  parameter int N_EPOCH = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  epoch_sched_if.master     ctl,
  output logic [7:0]        epoch,
  output logic [ADDR_W:0]   miss_count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    IDLE, GAP_T, ISSUE_T, WAIT_T, GAP_V, ISSUE_V, WAIT_V, FIN, FAULT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_T   = ADDR_W'(N_TRAIN - 1);
  localparam logic [ADDR_W-1:0] LAST_V   = ADDR_W'(N_VAL - 1);
  localparam logic [7:0]        LAST_E   = 8'(N_EPOCH - 1);
  localparam logic [7:0]        TMO      = 8'(TIMEOUT);
  localparam logic [ADDR_W:0]   MISS_MAX = '1;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wait_cnt;
  logic              tr_q, vl_q, end_q;

  logic              active, waiting, abort_hit, tmo_hit;
  logic              accept_t, accept_v, run_start, last_t, last_v;
  logic [ADDR_W:0]   miss_next;

  assign ctl.TR          = tr_q;
  assign ctl.VL          = vl_q;
  assign ctl.END         = end_q;
  assign ctl.sample_addr = addr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Qualify this cycle's events (abort > timeout > strobe) and pick the next state
  always_comb begin
    next_state = state;
    active     = (state != IDLE) && (state != FAULT);
    waiting    = (state == WAIT_T) || (state == WAIT_V);
    abort_hit  = active && abort;
    // The counter counts waiting cycles including the current one, so a
    // strobe on the edge where it first reaches TMO is still taken.
    tmo_hit    = waiting && !abort_hit && (wait_cnt == TMO);
    accept_t   = (state == WAIT_T) && ctl.S_Train && !abort_hit && !tmo_hit;
    accept_v   = (state == WAIT_V) && ctl.S_Error && !abort_hit && !tmo_hit;
    run_start  = !active && start;
    last_t     = (addr_q == LAST_T);
    last_v     = (addr_q == LAST_V);
    miss_next  = miss_count;
    if (ctl.val_miss && (miss_count != MISS_MAX)) miss_next = miss_count + 1'b1;

    if (abort_hit) begin
      next_state = IDLE;
    end else if (tmo_hit) begin
      next_state = FAULT;
    end else begin
      case (state)
        IDLE, FAULT: if (start) next_state = GAP_T;
        GAP_T:       next_state = ISSUE_T;
        ISSUE_T:     next_state = WAIT_T;
        WAIT_T:      if (accept_t) next_state = last_t ? GAP_V : GAP_T;
        GAP_V:       next_state = ISSUE_V;
        ISSUE_V:     next_state = WAIT_V;
        WAIT_V: begin
          if (accept_v) begin
            if (last_v) begin
`ifdef EPOCH_SCHED_EARLY_STOP_EN
              if ((epoch == LAST_E) || (miss_next == '0)) next_state = FIN;
`else
              if (epoch == LAST_E) next_state = FIN;
`endif
              else next_state = GAP_T;
            end else begin
              next_state = GAP_V;
            end
          end
        end
        FIN:         next_state = IDLE;
        default:     next_state = IDLE;
      endcase
    end
  end

  // Registered pulses, wait counter and sample/epoch/miss bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_q        <= 1'b0;
      vl_q        <= 1'b0;
      end_q       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      epoch       <= '0;
      miss_count  <= '0;
    end else begin
      tr_q  <= (state == ISSUE_T) && !abort_hit;
      vl_q  <= (state == ISSUE_V) && !abort_hit;
      end_q <= abort_hit || tmo_hit;
      done  <= (state == FIN) && !abort_hit;
      busy  <= (next_state != IDLE) && (next_state != FAULT);

      if ((state == ISSUE_T) || (state == ISSUE_V)) wait_cnt <= 8'd1;
      else if (waiting && (wait_cnt != TMO))        wait_cnt <= wait_cnt + 8'd1;

      if (tmo_hit) timeout_err <= 1'b1;

      if (run_start) begin
        epoch       <= '0;
        addr_q      <= '0;
        miss_count  <= '0;
        timeout_err <= 1'b0;
      end

      if (accept_t) begin
        if (last_t) begin
          addr_q     <= '0;
          miss_count <= '0;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end

      if (accept_v) begin
        miss_count <= miss_next;
        if (last_v) begin
          addr_q <= '0;
          if (next_state == GAP_T) epoch <= epoch + 8'd1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/epoch_sched.md
# epoch_sched

Epoch sequencer that drives the network's phase controller from the initiator side. It issues one-cycle `TR` (train-sample) and `VL` (validate-sample) command pulses and presents the current sample address to the sample memory. It waits for the controller's `S_Train` / `S_Error` completion strobes and counts samples and epochs. It also tallies validation misses and aborts a hung pass with `END`.

## Interface
- `N_TRAIN`, 16: training samples per epoch (1..2^ADDR_W).
- `N_VAL`, 4: validation samples per epoch (1..2^ADDR_W).
- `N_EPOCH`, 8: epochs per run (1..256).
- `ADDR_W`, 8: sample address width.
- `TIMEOUT`, 63: max cycles to wait for a completion strobe (1..255).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; starts a run from IDLE or FAULT.
- `abort`  in  1  level; stops any run in progress.
- `S_Train`  in  1  training-pass complete strobe from the controller.
- `S_Error`  in  1  validation-pass complete strobe from the controller.
- `val_miss`  in  1  validation result for the current sample; qualified by `S_Error`.
- `TR`  out  1  one-cycle pulse that starts a training pass.
- `VL`  out  1  one-cycle pulse that starts a validation pass.
- `END`  out  1  one-cycle pulse that forces the controller idle.
- `sample_addr`  out  ADDR_W  index of the sample in the current pass.
- `epoch`  out  8  current epoch index.
- `miss_count`  out  ADDR_W+1  misses in the current or latest validation pass.
- `busy`  out  1  high in every state except IDLE and FAULT.
- `done`  out  1  one-cycle pulse when a run completes.
- `timeout_err`  out  1  sticky; set when a completion strobe times out.

## Operation
- States: IDLE, GAP_T, ISSUE_T, WAIT_T, GAP_V, ISSUE_V, WAIT_V, FIN, FAULT.
- IDLE, on `start`:
  - clear `epoch`, `sample_addr`, `miss_count` and `timeout_err`;
  - go to GAP_T.
- GAP_T and GAP_V: one idle cycle, so the controller finishes its own reset. They go to ISSUE_T and ISSUE_V respectively.
- ISSUE_T drives `TR`=1 for exactly one cycle, then goes to WAIT_T.
- WAIT_T, on `S_Train`:
  - if `sample_addr`==N_TRAIN-1: set `sample_addr`=0, clear `miss_count`, go to GAP_V;
  - otherwise: increment `sample_addr`, go to GAP_T.
- ISSUE_V drives `VL`=1 for exactly one cycle, then goes to WAIT_V.
- WAIT_V, on `S_Error`:
  - `miss_count` increments if `val_miss`=1;
  - if `sample_addr`==N_VAL-1: set `sample_addr`=0, then
    - if `epoch`==N_EPOCH-1, go to FIN;
    - otherwise increment `epoch` and go to GAP_T;
  - otherwise: increment `sample_addr`, go to GAP_V.
- FIN: `done`=1 for one cycle, then IDLE.
  - `epoch`, `sample_addr` and `miss_count` hold their values until the next `start`.
- Timeout:
  - a wait counter clears on entry to WAIT_T or WAIT_V and increments each cycle spent there;
  - when it reaches TIMEOUT with no strobe: `END`=1 for one cycle, `timeout_err` set, go to FAULT.
- FAULT: `busy`=0. `start` behaves as in IDLE and also clears `timeout_err`.
- `abort` in any state other than IDLE or FAULT: `END`=1 for one cycle, go to IDLE. Counters hold.
- Priority within a cycle: `abort` > timeout > strobe.
- Ignored inputs:
  - a strobe outside its matching WAIT state;
  - `start` while `busy`=1;
  - `val_miss` unless `S_Error`=1 in WAIT_V.
- `miss_count` saturates at all-ones.

## Timing
- Reset values:
  - state IDLE;
  - `TR`, `VL`, `END`, `done`, `busy`, `timeout_err` = 0;
  - `sample_addr`, `epoch`, `miss_count` = 0.
- All outputs are registered.
- `start` sampled high → `busy`=1 on the next edge → `TR`=1 two edges after that (one GAP cycle).
- Completion strobe sampled → next `TR`/`VL` pulse follows 2 cycles later.
- `sample_addr` is stable from the cycle of the `TR`/`VL` pulse until the matching strobe is sampled.
- Strobes are sampled at the rising edge. The controller holds each strobe for one full cycle, so each strobe is counted exactly once.
- A strobe that arrives on the same edge the counter hits TIMEOUT is accepted, because the timeout check applies only to a counter value already at TIMEOUT.

## Configuration
- `EPOCH_SCHED_EARLY_STOP_EN` defined: a validation pass that ends with `miss_count`==0 goes to FIN immediately, so the run finishes early regardless of `epoch`.
- Not defined: the run always executes N_EPOCH epochs, and the early-stop logic is absent.

## Test plan
- N_TRAIN=2, N_VAL=1, N_EPOCH=2, responder replies 21 cycles after `TR` and 9 cycles after `VL`, `start` pulsed, `val_miss`=1 → 4 `TR` pulses with `sample_addr` 0,1,0,1; 2 `VL` pulses; one `done`; final `epoch`=1, `miss_count`=1.
- Same run with `val_miss`=0 and EARLY_STOP defined → `done` after the first `VL`, `epoch`=0; without EARLY_STOP the run continues to `epoch`=1.
- No responder, TIMEOUT=5 → one `TR`, then `END` exactly 5 cycles after entering WAIT_T, `timeout_err`=1, `busy`=0; `start` then clears `timeout_err` and a new run begins.
- `abort` asserted in the same cycle as `S_Train` → `END` pulse, IDLE, `sample_addr` not incremented.
- `rst_n` dropped while in WAIT_V → all outputs return to their reset values immediately; a later `start` runs normally from `epoch` 0.
- `start` held high for the whole run → no restart mid-run; a new run begins right after `done` because `start` is still high in IDLE.
